div_ctrl: RTL and testbench

Front-end/back-end controller wrapped around the iterative unsigned divider core, between the Ex stage and the core. Accepts one RV64M divide/remainder request at a time and resolves divide-by-zero and signed-overflow cases locally without launching the core. All other requests are converted to unsigned magnitudes, launched on the core, and the core's quotient/remainder is sign-corrected, selected and sign-extended (W ops). Produces a one-cycle write-back response.

---
 rtl/div_ctrl_if.sv | 31 +++
 rtl/div_ctrl.sv | 107 ++++++++++
 tb/tb_div_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: Ex-side request/response and divider-core handshake bundle for div_ctrl
interface div_ctrl_if;
    logic        req_valid;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [4:0]  req_waddr;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic        busy;
    logic [1:0]  div_hold_flag;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_hold_end;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [4:0]  resp_waddr;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_waddr, req_rs1, req_rs2,
        input  quotient, remainder, div_hold_end,
        output busy, div_hold_flag, dividend, divisor, resp_valid, resp_data, resp_waddr
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_waddr, req_rs1, req_rs2,
        output quotient, remainder, div_hold_end,
        input  busy, div_hold_flag, dividend, divisor, resp_valid, resp_data, resp_waddr
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: RV64M divide/remainder front/back end around an iterative unsigned divider core
module div_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    div_ctrl_if.slave  io_div
);
    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_LAUNCH = 4'b0010;
    localparam logic [3:0] S_WAIT   = 4'b0100;
    localparam logic [3:0] S_DONE   = 4'b1000;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic        r_word;
    logic        r_rem;
    logic        r_qneg;
    logic        r_rneg;
    logic [4:0]  r_waddr;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_result;

    // Request decode; only funct3 values 1xx with a MUL/DIV opcode are real requests
    logic        w_word;
    logic        w_sgn;
    logic        w_rem;
    logic        w_accept;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_min;
    logic        w_dz;
    logic        w_ovf;
    logic        w_sa;
    logic        w_sb;
    logic [63:0] w_q;
    logic [63:0] w_r;

    assign w_word   = io_div.req_opcode == 7'b0111011;
    assign w_sgn    = ~io_div.req_funct3[0];
    assign w_rem    = io_div.req_funct3[1];
    assign w_accept = r_state[0] & io_div.req_valid & io_div.req_funct3[2]
                    & (w_word | io_div.req_opcode == 7'b0110011);
    assign w_a      = ~w_word ? io_div.req_rs1
                    : {{32{w_sgn & io_div.req_rs1[31]}}, io_div.req_rs1[31:0]};
    assign w_b      = ~w_word ? io_div.req_rs2
                    : {{32{w_sgn & io_div.req_rs2[31]}}, io_div.req_rs2[31:0]};
    assign w_min    = w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_dz     = w_b == 64'd0;
    assign w_ovf    = w_sgn & (w_a == w_min) & (&w_b);
    assign w_sa     = w_sgn & w_a[63];
    assign w_sb     = w_sgn & w_b[63];
    assign w_q      = r_qneg ? -io_div.quotient : io_div.quotient;
    assign w_r      = r_rneg ? -io_div.remainder : io_div.remainder;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state: specials skip the core and answer directly from IDLE
    always_comb begin
        w_next = r_state[0] ? (!w_accept ? S_IDLE : (w_dz | w_ovf) ? S_DONE : S_LAUNCH)
               : r_state[1] ? S_WAIT
               : r_state[2] ? (io_div.div_hold_end ? S_DONE : S_WAIT)
               : S_IDLE;
    end

    // Operand/result latches: special results and magnitudes on accept, core result on completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word   <= 1'b0;
            r_rem    <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_waddr  <= 5'd0;
            r_a      <= 64'd0;
            r_b      <= 64'd0;
            r_result <= 64'd0;
        end else if (w_accept) begin
            r_word   <= w_word;
            r_rem    <= w_rem;
            r_qneg   <= w_sa ^ w_sb;
            r_rneg   <= w_sa;
            r_waddr  <= io_div.req_waddr;
            r_a      <= w_sa ? -w_a : w_a;
            r_b      <= w_sb ? -w_b : w_b;
            r_result <= w_dz ? (w_rem ? w_a : '1) : (w_rem ? 64'd0 : w_a);
        end else if (r_state[2] && io_div.div_hold_end) begin
            r_result <= r_rem ? w_r : w_q;
        end
    end

    // Outputs decode registered state only; W results are re-sign-extended from bit 31
    always_comb begin
        io_div.busy          = ~r_state[0];
        io_div.div_hold_flag = r_state[1] ? 2'b10 : 2'b00;
        io_div.dividend      = r_state[1] ? r_a : 64'd0;
        io_div.divisor       = r_state[1] ? r_b : 64'd0;
        io_div.resp_valid    = r_state[3];
        io_div.resp_data     = !r_state[3] ? 64'd0
                             : r_word ? {{32{r_result[31]}}, r_result[31:0]} : r_result;
        io_div.resp_waddr    = r_state[3] ? r_waddr : 5'd0;
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural divider core
module tb_div_ctrl;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPW   = 7'b0111011;
    localparam logic [2:0] FDIV  = 3'b100;
    localparam logic [2:0] FDIVU = 3'b101;
    localparam logic [2:0] FREM  = 3'b110;
    localparam logic [2:0] FREMU = 3'b111;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  wa;
        int          lat;
        int          launches;
        logic [63:0] ma;
        logic [63:0] mb;
        int          t0;
        int          l0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_launch = 0;
    int core_lat = 67;
    int cnt = -1;
    logic [63:0] ca, cb;

    div_ctrl_if ifc ();
    div_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .io_div(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] res, output bit launch,
                                  output logic [63:0] ma, output logic [63:0] mb);
        bit w, s, rm;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sbb;
        logic [31:0] r32;
        logic [63:0] ea, eb;
        w = (op == OPW);
        s = !f3[0];
        rm = f3[1];
        sa32 = x[31:0];
        sb32 = y[31:0];
        sa = x;
        sbb = y;
        ea = !w ? x : s ? 64'(sa32) : {32'b0, x[31:0]};
        eb = !w ? y : s ? 64'(sb32) : {32'b0, y[31:0]};
        launch = 1'b1;
        res = '0;
        if (w) begin
            if (y[31:0] == 32'd0) begin
                r32 = rm ? x[31:0] : 32'hFFFF_FFFF;
                launch = 1'b0;
            end else if (s && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) begin
                r32 = rm ? 32'd0 : x[31:0];
                launch = 1'b0;
            end else if (s) r32 = rm ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            else r32 = rm ? x[31:0] % y[31:0] : x[31:0] / y[31:0];
            res = {{32{r32[31]}}, r32};
        end else begin
            if (y == 64'd0) begin
                res = rm ? x : 64'hFFFF_FFFF_FFFF_FFFF;
                launch = 1'b0;
            end else if (s && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) begin
                res = rm ? 64'd0 : x;
                launch = 1'b0;
            end else if (s) res = rm ? 64'(sa % sbb) : 64'(sa / sbb);
            else res = rm ? x % y : x / y;
        end
        ma = (s && ea[63]) ? -ea : ea;
        mb = (s && eb[63]) ? -eb : eb;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] wa, input logic [63:0] x, input logic [63:0] y);
        ifc.req_valid  = v;
        ifc.req_opcode = op;
        ifc.req_funct3 = f3;
        ifc.req_waddr  = wa;
        ifc.req_rs1    = x;
        ifc.req_rs2    = y;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] wa,
                        input logic [63:0] x, input logic [63:0] y, input logic [63:0] want);
        exp_t e;
        bit l;
        logic [63:0] dummy;
        int g = 0;
        while (ifc.busy && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        model(op, f3, x, y, dummy, l, e.ma, e.mb);
        e.data = want;
        e.wa = wa;
        e.launches = int'(l);
        e.lat = l ? core_lat + 2 : 1;
        e.t0 = cyc;
        e.l0 = n_launch;
        sb.push_back(e);
        drive(1'b1, op, f3, wa, x, y);
        @(posedge clk); #1;
        drive(1'b0, 7'd0, 3'd0, 5'd0, 64'd0, 64'd0);
    endtask

    task automatic wait_resp();
        int g = 0;
        while (sb.size() > 0 && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(ifc.busy), 64'd0);
        check({tag, "_flag"}, 64'(ifc.div_hold_flag), 64'd0);
        check({tag, "_dividend"}, ifc.dividend, 64'd0);
        check({tag, "_divisor"}, ifc.divisor, 64'd0);
        check({tag, "_rvalid"}, 64'(ifc.resp_valid), 64'd0);
        check({tag, "_rdata"}, ifc.resp_data, 64'd0);
        check({tag, "_rwaddr"}, 64'(ifc.resp_waddr), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural core: ends core_lat cycles after the LAUNCH cycle
    initial begin
        ifc.div_hold_end = 1'b0;
        ifc.quotient = '0;
        ifc.remainder = '0;
        forever begin
            @(posedge clk); #1;
            ifc.div_hold_end = 1'b0;
            if (!rst_n) cnt = -1;
            else if (ifc.div_hold_flag == 2'b10) begin
                ca = ifc.dividend;
                cb = ifc.divisor;
                cnt = core_lat;
                n_launch++;
                if (sb.size() > 0) begin
                    check("core_dividend", ca, sb[0].ma);
                    check("core_divisor", cb, sb[0].mb);
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifc.quotient = ca / cb;
                    ifc.remainder = ca % cb;
                    ifc.div_hold_end = 1'b1;
                end
            end
        end
    end

    // Response monitor
    initial forever begin
        @(negedge clk);
        if (ifc.resp_valid) begin
            exp_t e;
            if (sb.size() == 0) check("spurious_resp", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("resp_data", ifc.resp_data, e.data);
                check("resp_waddr", 64'(ifc.resp_waddr), 64'(e.wa));
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
                check("launches", 64'(n_launch - e.l0), 64'(e.launches));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] x, y, r, m1, m2;
        bit          l;
        drive(1'b0, 7'd0, 3'd0, 5'd0, 64'd0, 64'd0);
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(OP, FDIV, 5'd1, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA); wait_resp();
        send(OP, FREM, 5'd2, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE); wait_resp();
        send(OP, FDIVU, 5'd3, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF); wait_resp();
        send(OP, FREMU, 5'd4, 64'h1234, 64'd0, 64'h1234); wait_resp();
        send(OP, FDIV, 5'd5, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000); wait_resp();
        send(OP, FREM, 5'd6, 64'h8000_0000_0000_0000, '1, 64'd0); wait_resp();
        send(OPW, FDIV, 5'd7, 64'h1111_1111_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000); wait_resp();
        send(OPW, FDIVU, 5'd8, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF); wait_resp();
        send(OPW, FREMU, 5'd9, 64'hFFFF_FFF7, 64'd4, 64'd3); wait_resp();
        send(OPW, FREM, 5'd10, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF); wait_resp();

        core_lat = 1;
        send(OP, FDIVU, 5'd11, 64'd100, 64'd7, 64'd14); wait_resp();
        core_lat = 67;

        // A second request during WAIT must be ignored
        send(OP, FDIV, 5'd12, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        repeat (10) @(posedge clk);
        #1;
        drive(1'b1, OP, FDIVU, 5'd20, 64'd49, 64'd7);
        repeat (5) @(posedge clk);
        #1;
        drive(1'b0, 7'd0, 3'd0, 5'd0, 64'd0, 64'd0);
        wait_resp();
        repeat (4) @(posedge clk);
        #1;
        check("ignore_idle_busy", 64'(ifc.busy), 64'd0);

        // Reset mid-WAIT drops the operation
        drive(1'b1, OP, FDIVU, 5'd21, 64'd1000, 64'd3);
        @(posedge clk); #1;
        drive(1'b0, 7'd0, 3'd0, 5'd0, 64'd0, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(ifc.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(ifc.busy), 64'd0);
        send(OP, FDIVU, 5'd22, 64'd100, 64'd7, 64'd14); wait_resp();

        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 1) ? OP : OPW;
            f3 = 3'(4 + $urandom_range(0, 3));
            x = {$urandom, $urandom};
            y = (i % 4 == 0) ? 64'd0 : (i % 4 == 1) ? 64'($urandom_range(1, 100)) : {$urandom, $urandom};
            if ($urandom_range(0, 1)) y = -y;
            if (i == 5) begin x = 64'hFFFF_FFFF_8000_0000; y = '1; end
            core_lat = $urandom_range(1, 80);
            model(op, f3, x, y, r, l, m1, m2);
            send(op, f3, 5'(i + 1), x, y, r);
            wait_resp();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
